conv_coprocessor_datapath: RTL

- Arithmetic and addressing datapath for the 1D convolution coprocessor; sits directly downstream of the convolution control FSM.
- Consumes the FSM's control strobes and returns the three loop comparator flags the FSM branches on.
- Drives read addresses into the X and Y sample memories and the write port of the Z result memory.
- Computes Z[i] = sum over j of X[j]*Y[i-j], for i = 0..size_x+size_y-2; all data is unsigned.

---
 rtl/conv_coprocessor_datapath.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conv_coprocessor_datapath.sv
// 1D convolution coprocessor datapath: loop counters, comparators, MAC, Z write port.
// Optional output saturation when CONV_SAT_EN is defined (truncation otherwise).
module conv_coprocessor_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W:0]   size_x,
  input  logic [ADDR_W:0]   size_y,
  input  logic              sel_i,
  input  logic              i_enable,
  input  logic              sel_j,
  input  logic              j_enable,
  input  logic              currentZ_en,
  input  logic              currentZ_clr,
  input  logic              writeZ,
  output logic              comp_i_out,
  output logic              comp_j_out,
  output logic              comp_indexH_out,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [ADDR_W-1:0] y_addr,
  input  logic [DATA_W-1:0] y_data,
  output logic              z_we,
  output logic [ADDR_W:0]   z_addr,
  output logic [OUT_W-1:0]  z_data,
  output logic              sat_flag
);

  localparam int ACC_W = 2*DATA_W + ADDR_W + 1;
  localparam int CW    = ADDR_W + 1;
  localparam int DW    = ADDR_W + 2;

  logic             start_q;
  logic             start_rise;
  logic             armed;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    j_q;
  logic [CW-1:0]    i_d;
  logic [CW-1:0]    j_d;
  logic [CW-1:0]    size_x_q;
  logic [CW-1:0]    size_y_q;
  logic [DW-1:0]    i_lim;
  logic [DW-1:0]    diff;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;
  logic [OUT_W-1:0] z_val;
  logic             z_clip;
  logic             z_fire;

  assign start_rise = start & ~start_q;
  assign z_fire     = writeZ & armed;

  always_comb begin
    i_d = i_q;
    unique case (1'b1)
      start_rise:         i_d = '0;
      i_enable & sel_i:   i_d = '0;
      i_enable & ~sel_i:  i_d = i_q + CW'(1);
      default:            i_d = i_q;
    endcase
  end

  always_comb begin
    j_d = j_q;
    unique case (1'b1)
      start_rise:         j_d = '0;
      j_enable & sel_j:   j_d = '0;
      j_enable & ~sel_j:  j_d = j_q + CW'(1);
      default:            j_d = j_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q  <= 1'b0;
      armed    <= 1'b0;
      size_x_q <= '0;
      size_y_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
    end else begin
      start_q <= start;
      i_q     <= i_d;
      j_q     <= j_d;
      if (start_rise) begin
        armed    <= 1'b1;
        size_x_q <= size_x;
        size_y_q <= size_y;
      end
    end
  end

  // Loop bounds; difference is one bit wider so i-j never wraps silently.
  assign i_lim = DW'(size_x_q) + DW'(size_y_q) - DW'(1);
  assign diff  = DW'(i_q) - DW'(j_q);

  assign comp_i_out      = (size_x_q != '0) & (size_y_q != '0)
                         & (DW'(i_q) < i_lim);
  assign comp_j_out      = j_q < size_x_q;
  assign comp_indexH_out = (j_q <= i_q) & (diff < DW'(size_y_q));

  assign x_addr = j_q[ADDR_W-1:0];
  assign y_addr = diff[ADDR_W-1:0];

  assign prod = ACC_W'(x_data) * ACC_W'(y_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (currentZ_clr) begin
      acc <= '0;
    end else if (currentZ_en) begin
      acc <= acc + prod;
    end
  end

`ifdef CONV_SAT_EN
  assign z_clip = |acc[ACC_W-1:OUT_W];
  assign z_val  = z_clip ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
`else
  assign z_clip = 1'b0;
  assign z_val  = acc[OUT_W-1:0];
`endif

  // Writes are suppressed until a start edge arms the block after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      z_we     <= 1'b0;
      z_addr   <= '0;
      z_data   <= '0;
      sat_flag <= 1'b0;
    end else begin
      z_we <= z_fire;
      if (z_fire) begin
        z_addr <= i_q;
        z_data <= z_val;
      end
      if (z_fire & z_clip) begin
        sat_flag <= 1'b1;
      end else if (start_rise) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule
